// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pkg
//  Purpose  : Shared rv32i front-end widths, NOP encoding and the fetch entry type.
//  Revision : 1.0  initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous prefetch FIFO of fetch entries with flush, count, full, empty.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
    import rv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  fetch_entry_t       data_i,
    output fetch_entry_t       data_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int c_PTR_W = $clog2(DEPTH);

    fetch_entry_t             mem_q [DEPTH];
    logic [c_PTR_W-1:0]       wr_ptr_q;
    logic [c_PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]         count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage carries no reset: the consumer masks the head whenever empty_o is set.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Fetch PC, credit-limited memory requests, prefetch FIFO, redirect squash.
//             Optional same-cycle response bypass when FETCH_BYPASS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import rv_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [ILEN-1:0] rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]    rsp_pc_q, rsp_pc_d;
    logic [c_CNT_W-1:0] outstanding_q, outstanding_d;
    logic [c_CNT_W-1:0] discard_q, discard_d;

    logic [c_CNT_W-1:0] w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic [c_CNT_W:0]   w_inflight;
    logic               w_accept;
    logic               w_rsp_live;
    logic               w_bypass;
    logic               w_bypass_take;
    logic               w_push;
    logic               w_pop;
    logic [XLEN-1:0]    w_redirect_pc;

    assign w_redirect_pc = redirect_pc & ~XLEN'(3);

    // Words already buffered consume credit as well as those still in flight.
    assign w_inflight = {1'b0, outstanding_q} + {1'b0, w_fifo_count};
    assign req_valid  = rst && !redirect && (w_inflight < (c_CNT_W + 1)'(DEPTH));
    assign req_addr   = fetch_pc_q;
    assign w_accept   = req_valid && req_ready;

    assign w_rsp_live = rsp_valid && !redirect && (discard_q == '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = rst && w_fifo_empty && !redirect && (discard_q == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_bypass_take = w_bypass && rsp_valid && instr_ready;
    assign w_push        = w_rsp_live && !w_bypass_take;
    assign w_pop         = !w_fifo_empty && instr_ready;

    assign w_push_entry.instr = rsp_data;
    assign w_push_entry.pc    = rsp_pc_q;

    always_comb begin
        instr_valid = !w_fifo_empty;
        instr       = w_fifo_empty ? NOP_INSTR : w_head.instr;
        instr_pc    = w_fifo_empty ? rsp_pc_q  : w_head.pc;
        if (w_bypass) begin
            instr_valid = rsp_valid;
            instr       = rsp_valid ? rsp_data : NOP_INSTR;
            instr_pc    = rsp_pc_q;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q + c_CNT_W'(w_accept) - c_CNT_W'(rsp_valid);

        discard_d = discard_q;
        if (redirect) begin
            discard_d = outstanding_d;
        end else if (rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - c_CNT_W'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = w_redirect_pc;
        end else if (w_accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        rsp_pc_d = rsp_pc_q;
        if (redirect) begin
            rsp_pc_d = w_redirect_pc;
        end else if (w_push || w_bypass_take) begin
            rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_push_entry),
        .data_o  (w_head),
        .count_o (w_fifo_count),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
        rsp_valid |-> (outstanding_q != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        w_push |-> (!w_fifo_full || w_pop));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed and random checks of fetch_unit against a PC-stream model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import rv_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          M_HOLD   = 0;
    localparam int          M_FIXED  = 1;
    localparam int          M_RAND   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          mode = M_FIXED;
    bit          rand_hs = 1'b0;
    bit          rr = 1'b0;
    bit          ir = 1'b0;
    bit          rd_now = 1'b0;
    logic [31:0] rd_tgt = '0;

    logic [31:0] q_addr [$];
    logic [31:0] d_pcs [$];
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] prev_addr = '0;
    bit          prev_pending = 1'b0;
    int          n_acc = 0;
    logic        last_req_valid;
    logic        last_instr_valid;
    logic [31:0] last_req_addr;

    // Memory contents: an injective scramble of the address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rand_hs) begin
            req_ready   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
        end else begin
            req_ready   = rr;
            instr_ready = ir;
            redirect    = rd_now;
            redirect_pc = rd_tgt;
        end
        rsp_valid = (mode != M_HOLD) && (q_addr.size() > 0) &&
                    ((mode == M_FIXED) || ($urandom_range(0, 3) != 0));
        rsp_data  = rsp_valid ? memw(q_addr[0]) : $urandom;
        #1;
        if (prev_pending && !redirect) begin
            chk("req_hold_valid", 32'(req_valid), 32'd1);
            chk("req_hold_addr", req_addr, prev_addr);
        end
        if (redirect) chk("req_valid_in_redirect", 32'(req_valid), 32'd0);
        if (req_valid) chk("credit_limit", 32'(q_addr.size() < DEPTH), 32'd1);
        if (req_valid && req_ready) begin
            chk("req_addr", req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            n_acc++;
        end
        if (instr_valid && instr_ready) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, memw(exp_pc));
            d_pcs.push_back(instr_pc);
            exp_pc = exp_pc + 32'd4;
        end
        last_req_valid   = req_valid;
        last_instr_valid = instr_valid;
        last_req_addr    = req_addr;
        prev_pending     = req_valid && !req_ready && !redirect;
        prev_addr        = req_addr;
        if (rsp_valid) void'(q_addr.pop_front());
        if (req_valid && req_ready) q_addr.push_back(req_addr);
        if (redirect) begin
            exp_pc  = redirect_pc & ~32'h3;
            exp_req = redirect_pc & ~32'h3;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        redirect    = 1'b0;
        rsp_valid   = 1'b0;
        req_ready   = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_instr_pc", instr_pc, RESET_PC);
        repeat (2) @(negedge clk);
        q_addr.delete();
        d_pcs.delete();
        exp_pc       = RESET_PC;
        exp_req      = RESET_PC;
        prev_pending = 1'b0;
        n_acc        = 0;
        rst          = 1'b1;
    endtask

    initial begin
        // In-order stream with a 1-cycle memory and a ready decoder
        do_reset();
        mode = M_FIXED; rr = 1'b1; ir = 1'b1;
        repeat (12) step();
        chk("t1_count", 32'(d_pcs.size() >= 3), 32'd1);
        chk("t1_pc0", d_pcs[0], 32'h0);
        chk("t1_pc1", d_pcs[1], 32'h4);
        chk("t1_pc2", d_pcs[2], 32'h8);

        // Decode stalled: credits cap the request count, then drain in order
        do_reset();
        mode = M_FIXED; rr = 1'b1; ir = 1'b0;
        repeat (10) step();
        chk("t2_requests", 32'(n_acc), 32'(DEPTH));
        chk("t2_req_idle", 32'(last_req_valid), 32'd0);
        ir = 1'b1;
        repeat (10) step();
        chk("t2_count", 32'(d_pcs.size() >= 2), 32'd1);
        chk("t2_pc0", d_pcs[0], 32'h0);
        chk("t2_pc1", d_pcs[1], 32'h4);

        // Redirect with two requests in flight squashes both responses
        do_reset();
        mode = M_HOLD; rr = 1'b1; ir = 1'b1;
        repeat (3) step();
        chk("t3_in_flight", 32'(q_addr.size()), 32'd2);
        rd_now = 1'b1; rd_tgt = 32'h100;
        step();
        rd_now = 1'b0;
        d_pcs.delete();
        mode = M_FIXED;
        repeat (10) step();
        chk("t3_count", 32'(d_pcs.size() >= 2), 32'd1);
        chk("t3_pc0", d_pcs[0], 32'h100);
        chk("t3_pc1", d_pcs[1], 32'h104);

        // Memory stall holds the request; a redirect mid-stall moves the address
        do_reset();
        mode = M_FIXED; rr = 1'b0; ir = 1'b1;
        repeat (3) step();
        chk("t4_stall_valid", 32'(last_req_valid), 32'd1);
        chk("t4_stall_addr", last_req_addr, RESET_PC);
        rd_now = 1'b1; rd_tgt = 32'h340;
        step();
        rd_now = 1'b0;
        repeat (2) step();
        chk("t4_new_valid", 32'(last_req_valid), 32'd1);
        chk("t4_new_addr", last_req_addr, 32'h340);
        rr = 1'b1;
        d_pcs.delete();
        repeat (8) step();
        chk("t4_count", 32'(d_pcs.size() >= 1), 32'd1);
        chk("t4_pc0", d_pcs[0], 32'h340);

        // Misaligned redirect target is fetched word aligned
        rd_now = 1'b1; rd_tgt = 32'h203;
        step();
        rd_now = 1'b0;
        d_pcs.delete();
        repeat (10) step();
        chk("t5_count", 32'(d_pcs.size() >= 1), 32'd1);
        chk("t5_pc0", d_pcs[0], 32'h200);

        // Reset with a full FIFO, then restart from RESET_PC
        do_reset();
        mode = M_FIXED; rr = 1'b1; ir = 1'b0;
        repeat (6) step();
        chk("t6_full_valid", 32'(last_instr_valid), 32'd1);
        do_reset();
        mode = M_FIXED; rr = 1'b1; ir = 1'b1;
        repeat (8) step();
        chk("t6_count", 32'(d_pcs.size() >= 1), 32'd1);
        chk("t6_pc0", d_pcs[0], RESET_PC);

        // Response-to-instruction latency with an empty FIFO
        do_reset();
        mode = M_HOLD; rr = 1'b1; ir = 1'b1;
        step();
        mode = M_FIXED; rr = 1'b0;
        step();
`ifdef FETCH_BYPASS_EN
        chk("t7_same_cycle_valid", 32'(last_instr_valid), 32'd1);
`else
        chk("t7_same_cycle_valid", 32'(last_instr_valid), 32'd0);
        step();
        chk("t7_next_cycle_valid", 32'(last_instr_valid), 32'd1);
`endif
        chk("t7_count", 32'(d_pcs.size()), 32'd1);

        // Random handshakes, memory latency and redirects
        do_reset();
        mode = M_RAND; rand_hs = 1'b1;
        repeat (3000) step();
        rand_hs = 1'b0;
        chk("rand_progress", 32'(d_pcs.size() > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
